peak_frame_rx: RTL

Receiving end of the peak-record stream produced by the FFT peak detector. Accepts framed records (freq, mag, phaseA, phaseB; 32-bit two's complement fixed point, 8 fractional bits), checks the sop/eop framing, and assembles each complete frame of NPEAKS records in a write bank. A finished frame is swapped into a read bank that downstream control logic reads by index under a ready/ack handshake.

---
 rtl/peak_pkg.sv | 37 +++
 rtl/peak_frame_rx_if.sv | 47 ++++
 rtl/peak_bank.sv | 41 ++++
 rtl/peak_frame_rx.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/peak_pkg.sv
// Shared types and constants for the FFT peak-record stream.
// Contents: peak_rec record type, receive FSM state enum, default frame
// size, bin width and fixed-point helpers (32-bit two's complement, 8 frac bits).
package peak_pkg;

    localparam int unsigned NPEAKS_DEF = 4;
    localparam int unsigned BIN_WIDTH  = 10;  // kHz per FFT bin
    localparam int unsigned FP_FRAC    = 8;

    // One peak record; every field is signed fixed point with FP_FRAC fraction bits.
    typedef struct packed {
        logic signed [31:0] freq;
        logic signed [31:0] mag;
        logic signed [31:0] phaseA;
        logic signed [31:0] phaseB;
    } peak_rec;

    typedef enum logic [1:0] {
        RX_IDLE = 2'd0,
        RX_FILL = 2'd1,
        RX_DROP = 2'd2
    } rx_state_e;

    // Index width that stays at least one bit for a single-record frame.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int fp_from_int(input int v);
        return v <<< FP_FRAC;
    endfunction

    function automatic int bin_to_khz_fp(input int bin);
        return fp_from_int(bin * int'(BIN_WIDTH));
    endfunction

endpackage

// File: rtl/peak_frame_rx_if.sv
// Bus bundle between the peak detector / control logic and peak_frame_rx.
// master: drives sink_* records, rd_en/rd_idx and frame_ack.
// slave : returns rd_valid/rd_* data, frame_ready, frame_cnt and overrun.
interface peak_frame_rx_if #(
    parameter int unsigned NPEAKS    = peak_pkg::NPEAKS_DEF,
    parameter int unsigned CNT_WIDTH = 16
);
    localparam int unsigned IDX_W = peak_pkg::idx_width(NPEAKS);

    logic                 sink_sop;
    logic                 sink_eop;
    logic                 sink_valid;
    logic [31:0]          sink_freq;
    logic [31:0]          sink_mag;
    logic [31:0]          sink_phaseA;
    logic [31:0]          sink_phaseB;

    logic                 rd_en;
    logic [IDX_W-1:0]     rd_idx;
    logic                 rd_valid;
    logic [31:0]          rd_freq;
    logic [31:0]          rd_mag;
    logic [31:0]          rd_phaseA;
    logic [31:0]          rd_phaseB;

    logic                 frame_ready;
    logic                 frame_ack;
    logic [CNT_WIDTH-1:0] frame_cnt;
    logic                 overrun;

    modport master (
        output sink_sop, sink_eop, sink_valid,
        output sink_freq, sink_mag, sink_phaseA, sink_phaseB,
        output rd_en, rd_idx, frame_ack,
        input  rd_valid, rd_freq, rd_mag, rd_phaseA, rd_phaseB,
        input  frame_ready, frame_cnt, overrun
    );

    modport slave (
        input  sink_sop, sink_eop, sink_valid,
        input  sink_freq, sink_mag, sink_phaseA, sink_phaseB,
        input  rd_en, rd_idx, frame_ack,
        output rd_valid, rd_freq, rd_mag, rd_phaseA, rd_phaseB,
        output frame_ready, frame_cnt, overrun
    );

endinterface

// File: rtl/peak_bank.sv
// NPEAKS-entry peak_rec register file: one write port, one registered read port.
// Ports: clk, rst (async, active-high clear of contents and read data),
//        we_i/waddr_i/wdata_i write port, re_i/raddr_i read request,
//        rdata_o record read in the previous cycle (zero when re_i was low).
module peak_bank
    import peak_pkg::*;
#(
    parameter int unsigned NPEAKS = NPEAKS_DEF,
    parameter int unsigned IDX_W  = idx_width(NPEAKS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  peak_rec          wdata_i,
    input  logic             re_i,
    input  logic [IDX_W-1:0] raddr_i,
    output peak_rec          rdata_o
);

    peak_rec mem_q [NPEAKS];
    peak_rec rdata_q;

    // Read data is forced to zero when not requested so the top can OR banks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NPEAKS); i++) begin
                mem_q[i] <= '0;
            end
            rdata_q <= '0;
        end else begin
            if (we_i) begin
                mem_q[waddr_i] <= wdata_i;
            end
            rdata_q <= re_i ? mem_q[raddr_i] : '0;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/peak_frame_rx.sv
// Receiver for framed peak records: checks sop/eop framing, fills a write
// bank and swaps it into the read bank when a full frame of NPEAKS arrives.
// Ports: clk, reset (async, active-high), bus (peak_frame_rx_if.slave),
//        err_cnt (saturating framing-error + overrun count, only when
//        PEAK_RX_ERRCNT_EN is defined).
module peak_frame_rx
    import peak_pkg::*;
#(
    parameter int unsigned NPEAKS    = NPEAKS_DEF,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    peak_frame_rx_if.slave       bus
`ifdef PEAK_RX_ERRCNT_EN
    ,
    output logic [CNT_WIDTH-1:0] err_cnt
`endif
);

    localparam int unsigned IDX_W = idx_width(NPEAKS);

    rx_state_e            state_q, state_d;
    logic [IDX_W-1:0]     wr_idx_q, wr_idx_d;
    logic                 bank_sel_q;        // write bank; read bank is the other one
    logic                 frame_ready_q;
    logic [CNT_WIDTH-1:0] frame_cnt_q;
    logic                 overrun_q;
    logic                 rd_valid_q;

    logic                 store_c, last_c, wr_en_c, done_c, swap_c, overrun_c;
    logic [IDX_W-1:0]     beat_idx_c;
    peak_rec              sink_rec_c;
    peak_rec              rdata_c [2];

    // A sop beat always lands at index 0, regardless of state.
    assign store_c    = bus.sink_valid && (bus.sink_sop || (state_q == RX_FILL));
    assign beat_idx_c = bus.sink_sop ? '0 : wr_idx_q;
    assign last_c     = (beat_idx_c == IDX_W'(NPEAKS - 1));
    assign sink_rec_c = '{freq: bus.sink_freq, mag: bus.sink_mag,
                          phaseA: bus.sink_phaseA, phaseB: bus.sink_phaseB};

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= RX_IDLE;
            wr_idx_q <= '0;
        end else begin
            state_q  <= state_d;
            wr_idx_q <= wr_idx_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d  = state_q;
        wr_idx_d = wr_idx_q;
        if (store_c) begin
            if (bus.sink_eop) begin
                state_d  = RX_IDLE;
                wr_idx_d = '0;
            end else if (last_c) begin
                state_d  = RX_DROP;
                wr_idx_d = '0;
            end else begin
                state_d  = RX_FILL;
                wr_idx_d = beat_idx_c + IDX_W'(1);
            end
        end else if (bus.sink_valid && (state_q == RX_DROP) && bus.sink_eop) begin
            state_d = RX_IDLE;
        end
    end

`ifdef PEAK_RX_ERRCNT_EN
    logic ferr_c;
`endif

    // FSM outputs
    always_comb begin
        wr_en_c = store_c;
        done_c  = store_c && bus.sink_eop && last_c;
`ifdef PEAK_RX_ERRCNT_EN
        ferr_c  = 1'b0;
        // early eop, missing eop, sop cutting a partial frame, or stray beat in IDLE
        if (store_c && (bus.sink_eop != last_c)) begin
            ferr_c = 1'b1;
        end
        if (bus.sink_valid && bus.sink_sop && (state_q == RX_FILL)) begin
            ferr_c = 1'b1;
        end
        if (bus.sink_valid && !bus.sink_sop && (state_q == RX_IDLE)) begin
            ferr_c = 1'b1;
        end
`endif
    end

    // An ack in the completion cycle frees the read bank just in time for the swap.
    assign swap_c    = done_c && (!frame_ready_q || bus.frame_ack);
    assign overrun_c = done_c && !swap_c;

    // Bank swap, frame status and read response
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bank_sel_q    <= 1'b0;
            frame_ready_q <= 1'b0;
            frame_cnt_q   <= '0;
            overrun_q     <= 1'b0;
            rd_valid_q    <= 1'b0;
        end else begin
            if (swap_c) begin
                bank_sel_q    <= ~bank_sel_q;
                frame_ready_q <= 1'b1;
                frame_cnt_q   <= frame_cnt_q + CNT_WIDTH'(1);
            end else if (bus.frame_ack) begin
                frame_ready_q <= 1'b0;
            end
            overrun_q  <= overrun_c;
            rd_valid_q <= bus.rd_en && frame_ready_q;
        end
    end

    // Only the read bank is read, and only while it holds a frame.
    for (genvar b = 0; b < 2; b++) begin : g_bank
        peak_bank #(
            .NPEAKS (NPEAKS),
            .IDX_W  (IDX_W)
        ) u_bank (
            .clk     (clk),
            .rst     (reset),
            .we_i    (wr_en_c && (bank_sel_q == 1'(b))),
            .waddr_i (beat_idx_c),
            .wdata_i (sink_rec_c),
            .re_i    (bus.rd_en && frame_ready_q && (bank_sel_q != 1'(b))),
            .raddr_i (bus.rd_idx),
            .rdata_o (rdata_c[b])
        );
    end

    assign bus.rd_valid    = rd_valid_q;
    assign bus.rd_freq     = rdata_c[0].freq   | rdata_c[1].freq;
    assign bus.rd_mag      = rdata_c[0].mag    | rdata_c[1].mag;
    assign bus.rd_phaseA   = rdata_c[0].phaseA | rdata_c[1].phaseA;
    assign bus.rd_phaseB   = rdata_c[0].phaseB | rdata_c[1].phaseB;
    assign bus.frame_ready = frame_ready_q;
    assign bus.frame_cnt   = frame_cnt_q;
    assign bus.overrun     = overrun_q;

`ifdef PEAK_RX_ERRCNT_EN
    logic [CNT_WIDTH-1:0] err_cnt_q;

    // Saturating error count; a framing error and overrun together count once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_cnt_q <= '0;
        end else if ((ferr_c || overrun_c) && (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + CNT_WIDTH'(1);
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule
